// File: rtl/muldiv_ctrl.sv
// Sequencer for the HI/LO multiply/divide unit: issues start pulses, tracks multiplier latency
// and divider completion, and drives the pipeline stall and HI/LO write strobe.
module muldiv_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_MAX = 40
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] Md_op,
  input  logic       Op_valid,
  input  logic       Rt_zero,
  input  logic       Flush,
  input  logic       Div_done,
  output logic       Mul_start,
  output logic       Div_start,
  output logic       Hilo_we,
  output logic       Hilo_src,
  output logic       Md_stall,
  output logic       Err_timeout,
  output logic [2:0] Dbg_state
);

  // Dbg_state encoding: 0 IDLE, 1 MUL_WAIT, 2 DIV_WAIT, 3 DONE, 4 DRAIN.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_WAIT = 3'd1,
    S_DIV_WAIT = 3'd2,
    S_DONE     = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  localparam logic [7:0] MUL_INIT = 8'(MUL_LAT - 1);
  localparam logic [8:0] DIV_LAST = 9'(DIV_MAX - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       src, src_nxt;
  logic       suppress, suppress_nxt;
  logic       err_set;
  logic       is_mul, is_div, long_op;
  logic       div_expired;

  assign is_mul  = (Md_op == 4'd7) || (Md_op == 4'd8) || (Md_op == 4'd9);
  assign is_div  = (Md_op == 4'd1) || (Md_op == 4'd2);
  assign long_op = Op_valid & (is_mul | is_div);

  // The timeout fires on the cycle whose increment would bring cnt to DIV_MAX-1.
  assign div_expired = ({1'b0, cnt} + 9'd1) >= DIV_LAST;

  assign Dbg_state = state;
  assign Hilo_src  = src;
  assign Md_stall  = Rst ? long_op : (long_op & (state != S_DONE) & !Flush);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      src         <= 1'b0;
      suppress    <= 1'b0;
      Err_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      src      <= src_nxt;
      suppress <= suppress_nxt;
      if (err_set) Err_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    src_nxt      = src;
    suppress_nxt = suppress;
    err_set      = 1'b0;
    Mul_start    = 1'b0;
    Div_start    = 1'b0;
    Hilo_we      = 1'b0;

    case (state)
      S_IDLE: begin
        if (long_op && !Flush) begin
          if (is_mul) begin
            Mul_start    = 1'b1;
            cnt_nxt      = MUL_INIT;
            src_nxt      = 1'b0;
            suppress_nxt = 1'b0;
            state_nxt    = S_MUL_WAIT;
          end else if (Rt_zero) begin
            // Divide by zero: skip the divider and leave HI/LO untouched.
            src_nxt      = 1'b1;
            suppress_nxt = 1'b1;
            state_nxt    = S_DONE;
          end else begin
            Div_start    = 1'b1;
            cnt_nxt      = 8'd0;
            src_nxt      = 1'b1;
            suppress_nxt = 1'b0;
            state_nxt    = S_DIV_WAIT;
          end
        end
      end

      S_MUL_WAIT: begin
        if (Flush) begin
          state_nxt = S_IDLE;
        end else if (cnt == 8'd0) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end

      S_DIV_WAIT: begin
        if (Flush) begin
          // The divider cannot be cancelled, so wait out its result in DRAIN.
          cnt_nxt   = cnt + 8'd1;
          state_nxt = S_DRAIN;
        end else if (Div_done) begin
          suppress_nxt = 1'b0;
          state_nxt    = S_DONE;
        end else if (div_expired) begin
          err_set      = 1'b1;
          suppress_nxt = 1'b1;
          state_nxt    = S_DONE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      S_DONE: begin
        if (!Flush) Hilo_we = !suppress;
        state_nxt = S_IDLE;
      end

      S_DRAIN: begin
        if (Div_done) begin
          state_nxt = S_IDLE;
        end else if (div_expired) begin
          err_set   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    if (Rst) begin
      Mul_start = 1'b0;
      Div_start = 1'b0;
      Hilo_we   = 1'b0;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: one instance with default parameters and one with DIV_MAX=8
// for the timeout case; HI/LO writes are checked against a queue of expected sources.
module tb_muldiv_ctrl;

  localparam logic [3:0] OP_NOP = 4'd0, OP_DIV = 4'd1, OP_DIVU = 4'd2, OP_MFLO = 4'd4,
                         OP_MUL = 4'd7, OP_MULT = 4'd8, OP_MULTU = 4'd9;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_DIV_WAIT = 3'd2, ST_DONE = 3'd3, ST_DRAIN = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] md_op = OP_NOP;
  logic       op_valid = 1'b0;
  logic       rt_zero = 1'b0;
  logic       flush = 1'b0;
  logic       div_done = 1'b0;

  logic       mul_start, div_start, hilo_we, hilo_src, md_stall, err_timeout;
  logic [2:0] dbg_state;
  logic       to_mul_start, to_div_start, to_hilo_we, to_hilo_src, to_md_stall, to_err_timeout;
  logic [2:0] to_dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [0:0] exp_q[$];

  muldiv_ctrl #(.MUL_LAT(4), .DIV_MAX(40)) u_dut (
    .Clk(clk), .Rst(rst), .Md_op(md_op), .Op_valid(op_valid), .Rt_zero(rt_zero),
    .Flush(flush), .Div_done(div_done), .Mul_start(mul_start), .Div_start(div_start),
    .Hilo_we(hilo_we), .Hilo_src(hilo_src), .Md_stall(md_stall),
    .Err_timeout(err_timeout), .Dbg_state(dbg_state)
  );

  muldiv_ctrl #(.MUL_LAT(4), .DIV_MAX(8)) u_dut_to (
    .Clk(clk), .Rst(rst), .Md_op(md_op), .Op_valid(op_valid), .Rt_zero(rt_zero),
    .Flush(flush), .Div_done(div_done), .Mul_start(to_mul_start), .Div_start(to_div_start),
    .Hilo_we(to_hilo_we), .Hilo_src(to_hilo_src), .Md_stall(to_md_stall),
    .Err_timeout(to_err_timeout), .Dbg_state(to_dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic vld, input logic rtz,
                       input logic fl, input logic dd);
    md_op    = op;
    op_valid = vld;
    rt_zero  = rtz;
    flush    = fl;
    div_done = dd;
  endtask

  // Scoreboard: every HI/LO write must match the next expected source.
  always @(negedge clk) begin
    if (hilo_we === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_unexpected_we", 32'd1, 32'd0);
      else chk("sb_hilo_src", {31'd0, hilo_src}, {31'd0, exp_q.pop_front()});
    end
  end

  initial begin
    // Reset with a long op presented: stall follows long_op, no pulses.
    drive(OP_MULT, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cyc(); next_cyc();
    sample();
    chk("rst_stall_long", md_stall, 1'b1);
    chk("rst_mul_start", mul_start, 1'b0);
    next_cyc();
    drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    sample();
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_hilo_we", hilo_we, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_stall", md_stall, 1'b0);

    // MULT: start at 0, stall 0..4, write at 5.
    next_cyc();
    drive(OP_MULT, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(1'b0);
    sample();
    chk("mult_start", mul_start, 1'b1);
    chk("mult_stall0", md_stall, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      next_cyc(); sample();
      chk("mult_stall_n", md_stall, 1'b1);
      chk("mult_no_restart", mul_start, 1'b0);
    end
    next_cyc(); sample();
    chk("mult_stall5", md_stall, 1'b0);
    chk("mult_we5", hilo_we, 1'b1);
    chk("mult_src5", hilo_src, 1'b0);
    next_cyc();
    drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("mult_idle", dbg_state, ST_IDLE);

    // DIVU with Div_done at cycle 12.
    next_cyc();
    drive(OP_DIVU, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(1'b1);
    sample();
    chk("divu_start", div_start, 1'b1);
    chk("divu_stall0", md_stall, 1'b1);
    for (int c = 1; c <= 11; c++) begin
      next_cyc(); sample();
      chk("divu_no_restart", div_start, 1'b0);
      chk("divu_stall_n", md_stall, 1'b1);
    end
    next_cyc();
    div_done = 1'b1;
    sample();
    chk("divu_stall12", md_stall, 1'b1);
    next_cyc();
    div_done = 1'b0;
    sample();
    chk("divu_state13", dbg_state, ST_DONE);
    chk("divu_we13", hilo_we, 1'b1);
    chk("divu_src13", hilo_src, 1'b1);
    chk("divu_stall13", md_stall, 1'b0);
    next_cyc();
    drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("divu_idle14", dbg_state, ST_IDLE);

    // DIV by zero: no start, one stall cycle, suppressed write.
    next_cyc();
    drive(OP_DIV, 1'b1, 1'b1, 1'b0, 1'b0);
    sample();
    chk("dz_no_start", div_start, 1'b0);
    chk("dz_stall0", md_stall, 1'b1);
    next_cyc(); sample();
    chk("dz_stall1", md_stall, 1'b0);
    chk("dz_state1", dbg_state, ST_DONE);
    chk("dz_we1", hilo_we, 1'b0);
    next_cyc();
    drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("dz_idle", dbg_state, ST_IDLE);

    // DIV flushed at 3, MULT at 4 held in DRAIN until Div_done at 9.
    next_cyc();
    drive(OP_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    chk("fl_div_start", div_start, 1'b1);
    for (int c = 1; c <= 2; c++) begin
      next_cyc(); sample();
      chk("fl_div_wait", dbg_state, ST_DIV_WAIT);
    end
    next_cyc();
    flush = 1'b1;
    sample();
    chk("fl_stall3", md_stall, 1'b0);
    next_cyc();
    drive(OP_MULT, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    chk("fl_drain4", dbg_state, ST_DRAIN);
    chk("fl_stall4", md_stall, 1'b1);
    for (int c = 5; c <= 9; c++) begin
      next_cyc();
      div_done = (c == 9);
      sample();
      chk("fl_mult_held", md_stall, 1'b1);
      chk("fl_no_mul_start", mul_start, 1'b0);
      chk("fl_no_we", hilo_we, 1'b0);
    end
    next_cyc();
    div_done = 1'b0;
    exp_q.push_back(1'b0);
    sample();
    chk("fl_mul_start10", mul_start, 1'b1);
    chk("fl_idle10", dbg_state, ST_IDLE);
    for (int c = 11; c <= 14; c++) begin
      next_cyc(); sample();
    end
    next_cyc(); sample();
    chk("fl_mult_we", hilo_we, 1'b1);
    next_cyc();
    drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout on the DIV_MAX=8 instance; reset both instances first.
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    next_cyc();
    drive(OP_DIV, 1'b1, 1'b0, 1'b0, 1'b0);
    sample();
    chk("to_start", to_div_start, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      next_cyc(); sample();
      chk("to_err_low", to_err_timeout, 1'b0);
      chk("to_stall", to_md_stall, 1'b1);
    end
    next_cyc(); sample();
    chk("to_err8", to_err_timeout, 1'b1);
    chk("to_done8", to_dbg_state, ST_DONE);
    chk("to_we8", to_hilo_we, 1'b0);
    chk("to_stall8", to_md_stall, 1'b0);
    next_cyc();
    drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 9; c <= 12; c++) begin
      sample();
      chk("to_err_sticky", to_err_timeout, 1'b1);
      next_cyc();
    end
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    sample();
    chk("to_err_cleared", to_err_timeout, 1'b0);
    chk("main_no_err", err_timeout, 1'b0);

    // MUL, MFLO, MULTU back to back; reset lands in MULTU's MUL_WAIT.
    next_cyc();
    drive(OP_MUL, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(1'b0);
    sample();
    chk("b2b_mul_start", mul_start, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      next_cyc(); sample();
    end
    chk("b2b_mul_we", hilo_we, 1'b1);
    next_cyc();
    md_op = OP_MFLO;
    sample();
    chk("b2b_mflo_stall", md_stall, 1'b0);
    chk("b2b_mflo_no_start", mul_start, 1'b0);
    next_cyc();
    md_op = OP_MULTU;
    exp_q.push_back(1'b0);
    sample();
    chk("b2b_multu_start", mul_start, 1'b1);
    next_cyc();
    next_cyc();
    rst = 1'b1;
    exp_q.delete();
    sample();
    chk("b2b_rst_stall", md_stall, 1'b1);
    chk("b2b_rst_we", hilo_we, 1'b0);
    next_cyc();
    rst = 1'b0;
    drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk("b2b_rst_idle", dbg_state, ST_IDLE);
    for (int c = 0; c < 4; c++) begin
      next_cyc(); sample();
      chk("b2b_no_stale_we", hilo_we, 1'b0);
    end
    next_cyc();
    drive(OP_MULTU, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(1'b0);
    sample();
    chk("post_rst_start", mul_start, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      next_cyc(); sample();
      chk("post_rst_stall", md_stall, 1'b1);
    end
    next_cyc(); sample();
    chk("post_rst_we", hilo_we, 1'b1);
    next_cyc();
    drive(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc(); next_cyc();

    // Final report
    chk("sb_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the HI/LO multiply/divide unit.
- Sits between the EX-stage decode and the fixed-latency multiplier / valid-handshake divider.
- Issues start pulses, counts multiplier latency, waits on divider completion, generates the pipeline stall and the HI/LO write strobe.
- Handles flush by draining in-flight divides, and handles divide-by-zero and divider timeout.

Parameters:
- MUL_LAT, 4: multiplier pipeline depth in cycles, from Mul_start to product valid; legal range 1..15.
- DIV_MAX, 40: maximum cycles spent in DIV_WAIT or DRAIN before declaring a timeout; legal range 2..255.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- Md_op  in  4  op code: 1 DIV, 2 DIVU, 3 MFHI, 4 MFLO, 5 MTHI, 6 MTLO, 7 MUL, 8 MULT, 9 MULTU; other values are NOP.
- Op_valid  in  1  EX stage holds a valid instruction carrying Md_op.
- Rt_zero  in  1  divisor operand equals zero; sampled at issue.
- Flush  in  1  kill the EX instruction this cycle.
- Div_done  in  1  divider result valid (one-cycle pulse).
- Mul_start  out  1  one-cycle launch pulse to the multiplier.
- Div_start  out  1  one-cycle tvalid pulse to the divider.
- Hilo_we  out  1  one-cycle write strobe: load HI/LO (or HI plus rd for MUL) from the unit result.
- Hilo_src  out  1  0 = multiplier result, 1 = divider result; valid while Hilo_we=1.
- Md_stall  out  1  freeze the pipeline front end.
- Err_timeout  out  1  sticky divider-timeout flag.

Behaviour:
- long_op = Op_valid & Md_op in {1,2,7,8,9}.
- States: IDLE, MUL_WAIT, DIV_WAIT, DONE, DRAIN. Encoding is free.
- Reset: state=IDLE, cnt=0, src=0, Err_timeout=0.
  - All pulse outputs are 0 in the cycle after Rst.
  - Md_stall = long_op while Rst is high.
- Md_stall (combinational) = long_op & (state != DONE) & !Flush.
  - Short ops (3..6) and NOP never stall.
- IDLE, long_op & !Flush:
  - Mul ops: Mul_start=1 combinationally this cycle; cnt<=MUL_LAT-1; -> MUL_WAIT.
  - Div ops with Rt_zero=1: no Div_start; -> DONE with src=1 and a suppressed write (HI/LO unchanged).
  - Div ops with Rt_zero=0: Div_start=1; cnt<=0; -> DIV_WAIT.
- MUL_WAIT: decrement cnt; at cnt==0 -> DONE with src=0.
  - A multiply therefore stalls exactly MUL_LAT+1 cycles; the instruction advances in the DONE cycle.
- DIV_WAIT:
  - Div_done=1 -> DONE with src=1.
  - Otherwise cnt++. When cnt reaches DIV_MAX-1 without Div_done: Err_timeout<=1; -> DONE with a suppressed write.
- DONE:
  - Hilo_we=1 unless the write was suppressed; Hilo_src=src; Md_stall=0; -> IDLE next cycle.
  - A new long_op in the following IDLE cycle issues normally (back-to-back ops are legal).
- Flush, highest priority after Rst:
  - From IDLE, MUL_WAIT or DONE: -> IDLE; no Hilo_we, no start pulse this cycle.
  - From DIV_WAIT: -> DRAIN (cnt keeps counting).
  - The multiplier needs no drain; its result is simply not written.
- DRAIN:
  - Any long_op is stalled; short ops pass.
  - Div_done -> IDLE with no write.
  - Timeout rules as in DIV_WAIT, but exit to IDLE.
  - A Div_done in the same cycle as a new issue is impossible because issue happens only from IDLE.
- Div_done while in IDLE, MUL_WAIT or DONE is ignored. This is a protocol error and not flagged.
- Md_op must stay stable while Md_stall=1. If Op_valid drops mid-operation without Flush, the operation completes and the write still occurs.
- Err_timeout is cleared only by Rst.

Test Plan:
- MUL_LAT=4; MULT with Op_valid held:
  - Mul_start at cycle 0.
  - Md_stall=1 for cycles 0..4, 0 at cycle 5.
  - Hilo_we=1, Hilo_src=0 at cycle 5.
- DIVU, Rt_zero=0, Div_done at cycle 12:
  - Div_start only at cycle 0.
  - DONE at cycle 13: Hilo_we=1, Hilo_src=1, Md_stall=0.
  - IDLE at cycle 14.
- DIV with Rt_zero=1:
  - No Div_start.
  - Md_stall=1 at cycle 0, 0 at cycle 1.
  - Hilo_we stays 0.
- DIV issued, Flush at cycle 3, then MULT presented at cycle 4, Div_done at cycle 9:
  - MULT is stalled through cycle 9.
  - Mul_start at cycle 10.
  - No Hilo_we from the divide.
- DIV_MAX=8, Div_done never arrives:
  - Err_timeout rises at cycle 8.
  - DONE has Hilo_we=0.
  - Err_timeout remains high until Rst.
- Back-to-back MUL then MFLO then MULTU, plus Rst asserted mid-MUL_WAIT:
  - MFLO never stalls.
  - After Rst: state IDLE, no stale Hilo_we, and the next op issues cleanly.
